// File: rtl/pe_acc_chain.sv
// pe_acc_chain: PE output stage. It has two accumulator banks. One bank
// collects partial sums while the other drains onto the valid/ready chain
// towards the right neighbour. After its own words have drained, a non-head
// PE forwards the left neighbour's stream until that stream's last beat.
//
// Ports
//   clk, rst                   clock and asynchronous active-high reset
//   cfg_len                    active entries per frame (0 or >DEPTH means DEPTH)
//   cfg_sat                    1 = saturate on overflow, 0 = wrap
//   cfg_head                   1 = leftmost PE, so there is no left stream to forward
//   acc_valid/acc_first        accumulate strobe, and overwrite instead of add
//   psum_in                    signed partial sum
//   swap_req/swap_ack          bank swap request (level) and one-cycle acknowledge
//   ovf_flag                   sticky overflow flag of the compute bank
//   in_valid/in_data/in_last   stream from the left PE, with in_ready back
//   out_valid/out_data/out_last stream to the right PE, with out_ready back
//   busy                       high while draining or forwarding
module pe_acc_chain #(
  parameter int DATA_W = 24,
  parameter int IN_W   = 24,
  parameter int DEPTH  = 32,
  parameter int LEN_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic                     cfg_sat,
  input  logic                     cfg_head,
  input  logic                     acc_valid,
  input  logic                     acc_first,
  input  logic signed [IN_W-1:0]   psum_in,
  input  logic                     swap_req,
  output logic                     swap_ack,
  output logic                     ovf_flag,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_PASS  = 2'd2;

  // An add of two DATA_W words has overflowed when the two top bits of the
  // DATA_W+1 result differ.
  function automatic logic sum_ovf(input logic signed [DATA_W:0] s);
    return s[DATA_W] ^ s[DATA_W-1];
  endfunction

  // Clamp to the signed DATA_W range when saturating. Otherwise keep the low
  // bits (two's-complement wrap). The true sign is s[DATA_W].
  function automatic logic signed [DATA_W-1:0] clip(input logic signed [DATA_W:0] s,
                                                    input logic sat);
    logic signed [DATA_W-1:0] max_v;
    logic signed [DATA_W-1:0] min_v;
    max_v = {1'b0, {(DATA_W-1){1'b1}}};
    min_v = {1'b1, {(DATA_W-1){1'b0}}};
    if (sat && sum_ovf(s)) begin
      return s[DATA_W] ? min_v : max_v;
    end
    return s[DATA_W-1:0];
  endfunction

  // Bank storage is never reset. The first pass of a frame uses acc_first.
  logic signed [DATA_W-1:0] mem_q [2][DEPTH];

  logic [1:0]               state_q, state_d;
  logic                     bank_sel_q, bank_sel_d;
  logic [AW-1:0]            acc_addr_q, acc_addr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic                     out_last_q, out_last_d;
  logic                     swap_ack_q, swap_ack_d;
  logic                     ovf_q, ovf_d;

  logic [LEN_W-1:0]         len_eff;
  logic [AW-1:0]            last_idx;
  logic signed [DATA_W:0]   old_x, psum_x, acc_sum;
  logic signed [DATA_W-1:0] acc_wr;
  logic                     acc_ovf;
  logic                     load, swap_go, pass_rdy, in_fire;

  always_comb begin
    len_eff  = (cfg_len == '0 || cfg_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len;
    last_idx = AW'(len_eff - LEN_W'(1));
  end

  // Accumulate datapath: read-modify-write of the compute bank entry
  always_comb begin
    old_x   = {mem_q[bank_sel_q][acc_addr_q][DATA_W-1], mem_q[bank_sel_q][acc_addr_q]};
    psum_x  = {{(DATA_W+1-IN_W){psum_in[IN_W-1]}}, psum_in};
    acc_sum = old_x + psum_x;
    if (acc_first) begin
      acc_wr  = psum_x[DATA_W-1:0];
      acc_ovf = 1'b0;
    end else begin
      acc_wr  = clip(acc_sum, cfg_sat);
      acc_ovf = sum_ovf(acc_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (acc_valid) begin
      mem_q[bank_sel_q][acc_addr_q] <= acc_wr;
    end
  end

  // Control: swap handshake, drain/forward FSM, output register
  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    acc_addr_d  = acc_addr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;

    load     = !out_valid_q || out_ready;
    swap_go  = swap_req && (state_q == S_IDLE) && (acc_addr_q == '0) && !acc_valid;
    pass_rdy = (state_q == S_PASS) && load;
    in_fire  = in_valid && pass_rdy;

    swap_ack_d = swap_go;

    if (acc_valid) begin
      acc_addr_d = (acc_addr_q == last_idx) ? '0 : acc_addr_q + AW'(1);
      if (acc_ovf) begin
        ovf_d = 1'b1;
      end
    end

    // A swap only happens with acc_valid low, so it never races an overflow.
    if (swap_go) begin
      bank_sel_d = ~bank_sel_q;
      ovf_d      = 1'b0;
      rd_ptr_d   = '0;
      state_d    = S_DRAIN;
    end

    case (state_q)
      S_DRAIN: begin
        if (load) begin
          out_data_d  = mem_q[~bank_sel_q][rd_ptr_q];
          out_valid_d = 1'b1;
          out_last_d  = cfg_head && (rd_ptr_q == last_idx);
          rd_ptr_d    = rd_ptr_q + AW'(1);
          if (rd_ptr_q == last_idx) begin
            state_d = cfg_head ? S_IDLE : S_PASS;
          end
        end
      end
      S_PASS: begin
        if (in_fire) begin
          out_data_d  = in_data;
          out_last_d  = in_last;
          out_valid_d = 1'b1;
          if (in_last) begin
            state_d = S_IDLE;
          end
        end else if (load) begin
          out_valid_d = 1'b0;
        end
      end
      default: begin
        if (load) begin
          out_valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bank_sel_q  <= 1'b0;
      acc_addr_q  <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      swap_ack_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      acc_addr_q  <= acc_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      swap_ack_q  <= swap_ack_d;
      ovf_q       <= ovf_d;
    end
  end

  assign swap_ack  = swap_ack_q;
  assign ovf_flag  = ovf_q;
  assign in_ready  = pass_rdy;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);

endmodule
